b_sel: RTL and testbench
========================

// Module: b_sel
// PURPOSE
//  - ALU operand-B select stage of the custom RV32I-style datapath.
//  - Decodes the 7-bit major opcode and chooses either register operand rs2 or the
//    immediate from the immediate generator. Registers the result for the execute stage.
//  - Also exports the select decision and an illegal-opcode flag to control/hazard logic.
// PARAMETERS
//  - W      32  datapath width (rs2, imm_out, rs2_out)
//  - OPLEN   7  opcode width; only 7 is supported (opcode constants are 7-bit)
// PORTS
//  - clk         in   1      rising-edge clock
//  - rst         in   1      reset, asynchronous, active-high
//  - rs2         in   W      register-file read data, source 2
//  - op          in   OPLEN  instruction opcode field (instr[6:0])
//  - imm_out     in   W      sign-extended immediate from the immediate generator
//  - rs2_out     out  W      registered ALU operand B
//  - sel_imm     out  1      registered: 1 = rs2_out holds the immediate, 0 = holds rs2
//  - op_illegal  out  1      registered: 1 = op is not a recognised opcode
// BEHAVIOUR
//  - Single clock (clk); reset is asynchronous and active-high (rst).
//  - While rst=1: rs2_out=0, sel_imm=0, op_illegal=0, forced immediately, not at the clock edge.
//  - Latency is 1 cycle. Inputs sampled at the rising clk edge appear on the outputs
//    after that edge. No handshake; a new value is accepted every cycle.
//  - Opcode decode (combinational, then registered):
//      0110011 R-type      -> rs2      sel_imm=0
//      1100011 branch      -> rs2      sel_imm=0  (comparison uses rs2)
//      0010011 I-type ALU  -> imm_out  sel_imm=1
//      0000011 load        -> imm_out  sel_imm=1
//      0100011 store       -> imm_out  sel_imm=1
//      1100111 JALR        -> imm_out  sel_imm=1
//      1101111 JAL         -> imm_out  sel_imm=1
//      0110111 LUI         -> imm_out  sel_imm=1
//      0010111 AUIPC       -> imm_out  sel_imm=1
//      any other (e.g. 1111111, 0000000) -> rs2_out=0, sel_imm=0, op_illegal=1
//  - Data is passed bit-exact, with no sign or width conversion. Width is W on all data paths.
//  - Reset deassertion: the first rising edge after rst falls loads the decoded value.
//    rst asserted mid-stream discards the in-flight value.
//  - X/Z on op is treated as illegal (default branch of a unique case).
// STRUCTURE
//  - Shared package bsel_pkg:
//    - localparam opcode constants OP_RTYPE, OP_ITYPE, OP_LOAD, OP_STORE,
//      OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC
//    - typedef enum {SRC_RS2, SRC_IMM, SRC_ZERO} bsrc_e
//  - Sub-module bsel_op_decode: purely combinational, op -> bsrc_e plus illegal flag.
//  - The top level holds the W-bit 3:1 mux and the output register with async reset.
// TESTING
//  - rs2=0x0000000A, imm_out=0x00000014 throughout unless noted.
//  - rst=1 with any op -> rs2_out=0, sel_imm=0, op_illegal=0 with no clk edge.
//  - op=0110011 (R) -> next edge: rs2_out=0x0000000A, sel_imm=0, op_illegal=0.
//  - op=0010011 (I) -> next edge: rs2_out=0x00000014, sel_imm=1.
//  - op=1111111 -> next edge: rs2_out=0x00000000, sel_imm=0, op_illegal=1.
//  - Sweep all 9 legal opcodes back-to-back, one per cycle:
//    - each output matches the decode table exactly 1 cycle later.
//    - the output changes on every cycle.
//  - rst pulsed between edges while rs2_out=0x14:
//    - outputs go to 0 asynchronously.
//    - after release, op=0110011 yields 0x0A on the first edge.

Source files
------------

// File: rtl/bsel_pkg.sv
// Shared definitions for the ALU operand-B select stage: opcode constants
// and the operand-source encoding produced by the opcode decoder.
package bsel_pkg;

  localparam int unsigned OPLEN = 7;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Where operand B comes from for a given opcode.
  typedef enum logic [1:0] {
    SRC_RS2  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_ZERO = 2'd2
  } bsrc_e;

endpackage : bsel_pkg

// File: rtl/bsel_op_decode.sv
// Combinational opcode decoder: maps the 7-bit major opcode to an operand-B
// source and flags anything that is not a recognised opcode (including X/Z).
module bsel_op_decode
  import bsel_pkg::*;
(
  input  logic [6:0] op_i,
  output bsrc_e      src_o,
  output logic       illegal_o
);

  // Decode opcode into operand source; unknown encodings select zero and flag illegal.
  always_comb begin
    src_o     = SRC_ZERO;
    illegal_o = 1'b0;
    unique case (op_i)
      OP_RTYPE,
      OP_BRANCH: begin
        src_o     = SRC_RS2;
        illegal_o = 1'b0;
      end
      OP_ITYPE,
      OP_LOAD,
      OP_STORE,
      OP_JALR,
      OP_JAL,
      OP_LUI,
      OP_AUIPC: begin
        src_o     = SRC_IMM;
        illegal_o = 1'b0;
      end
      default: begin
        src_o     = SRC_ZERO;
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule : bsel_op_decode

// File: rtl/b_sel.sv
// ALU operand-B select stage. Chooses rs2, the immediate or zero according to
// the opcode and registers the result, the select decision and an illegal flag
// for the execute stage. One cycle of latency, no handshake.
module b_sel
  import bsel_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned OPLEN = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     rs2,
  input  logic [OPLEN-1:0] op,
  input  logic [W-1:0]     imm_out,
  output logic [W-1:0]     rs2_out,
  output logic             sel_imm,
  output logic             op_illegal
);

  bsrc_e        src_s;
  logic         illegal_s;
  logic [W-1:0] b_d;
  logic         sel_imm_d;
  logic [W-1:0] b_q;
  logic         sel_imm_q;
  logic         illegal_q;

  bsel_op_decode u_dec (
    .op_i      (op),
    .src_o     (src_s),
    .illegal_o (illegal_s)
  );

  // Three-way operand mux; the zero leg is taken for illegal opcodes.
  always_comb begin
    b_d       = {W{1'b0}};
    sel_imm_d = 1'b0;
    case (src_s)
      SRC_RS2: begin
        b_d       = rs2;
        sel_imm_d = 1'b0;
      end
      SRC_IMM: begin
        b_d       = imm_out;
        sel_imm_d = 1'b1;
      end
      default: begin
        b_d       = {W{1'b0}};
        sel_imm_d = 1'b0;
      end
    endcase
  end

  // Output register; reset clears everything immediately, discarding any in-flight value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b_q       <= {W{1'b0}};
      sel_imm_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      b_q       <= b_d;
      sel_imm_q <= sel_imm_d;
      illegal_q <= illegal_s;
    end
  end

  assign rs2_out    = b_q;
  assign sel_imm    = sel_imm_q;
  assign op_illegal = illegal_q;

endmodule : b_sel

// File: tb/tb_b_sel.sv
// Scoreboard bench for b_sel: the driver pushes hand-computed expectations as
// it applies each vector; a monitor pops and compares one cycle later.
module tb_b_sel;

  logic        clk;
  logic        rst;
  logic [31:0] rs2;
  logic [6:0]  op;
  logic [31:0] imm_out;
  logic [31:0] rs2_out;
  logic        sel_imm;
  logic        op_illegal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [31:0] b;
    logic        sel;
    logic        ill;
    logic        chk_chg;
  } exp_t;

  exp_t        q[$];
  logic [31:0] prev_b;

  b_sel #(.W(32), .OPLEN(7)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs2        (rs2),
    .op         (op),
    .imm_out    (imm_out),
    .rs2_out    (rs2_out),
    .sel_imm    (sel_imm),
    .op_illegal (op_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Apply one vector at the falling edge and record what must appear after the next rising edge.
  task automatic drive(input string nm, input logic [6:0] o, input logic [31:0] r,
                       input logic [31:0] i, input logic [31:0] eb, input logic es,
                       input logic ei, input logic chg);
    exp_t e;
    @(negedge clk);
    op      = o;
    rs2     = r;
    imm_out = i;
    e.name = nm; e.b = eb; e.sel = es; e.ill = ei; e.chk_chg = chg;
    q.push_back(e);
  endtask

  // Monitor: just after each rising edge, compare DUT outputs with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, "_b"},   rs2_out, e.b);
      chk({e.name, "_sel"}, {31'd0, sel_imm}, {31'd0, e.sel});
      chk({e.name, "_ill"}, {31'd0, op_illegal}, {31'd0, e.ill});
      if (e.chk_chg) begin
        checks++;
        if (rs2_out === prev_b) begin
          errors++;
          $display("FAIL %s_change actual=%h required=not %h", e.name, rs2_out, prev_b);
        end
      end
    end
    prev_b = rs2_out;
  end

  initial begin
    int budget;
    rst     = 1'b1;
    rs2     = 32'h0000000A;
    imm_out = 32'h00000014;
    op      = 7'b0010011;
    #1;
    // Before any clock edge: reset alone must force outputs low.
    chk("rst_async_b",   rs2_out, 32'h0);
    chk("rst_async_sel", {31'd0, sel_imm}, 32'h0);
    chk("rst_async_ill", {31'd0, op_illegal}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    drive("r_type",  7'b0110011, 32'h0000000A, 32'h00000014, 32'h0000000A, 1'b0, 1'b0, 1'b0);
    drive("i_type",  7'b0010011, 32'h0000000A, 32'h00000014, 32'h00000014, 1'b1, 1'b0, 1'b0);
    drive("ill_ff",  7'b1111111, 32'h0000000A, 32'h00000014, 32'h00000000, 1'b0, 1'b1, 1'b0);
    drive("ill_00",  7'b0000000, 32'h0000000A, 32'h00000014, 32'h00000000, 1'b0, 1'b1, 1'b0);

    // Sweep all legal opcodes back-to-back with distinct data so every cycle differs.
    drive("sw_r",      7'b0110011, 32'h00000011, 32'h000000EE, 32'h00000011, 1'b0, 1'b0, 1'b1);
    drive("sw_i",      7'b0010011, 32'h000000EE, 32'h00000022, 32'h00000022, 1'b1, 1'b0, 1'b1);
    drive("sw_load",   7'b0000011, 32'h000000EE, 32'h00000033, 32'h00000033, 1'b1, 1'b0, 1'b1);
    drive("sw_store",  7'b0100011, 32'h000000EE, 32'h00000044, 32'h00000044, 1'b1, 1'b0, 1'b1);
    drive("sw_branch", 7'b1100011, 32'h80000055, 32'h000000EE, 32'h80000055, 1'b0, 1'b0, 1'b1);
    drive("sw_jal",    7'b1101111, 32'h000000EE, 32'hFFFFF066, 32'hFFFFF066, 1'b1, 1'b0, 1'b1);
    drive("sw_jalr",   7'b1100111, 32'h000000EE, 32'h00000077, 32'h00000077, 1'b1, 1'b0, 1'b1);
    drive("sw_lui",    7'b0110111, 32'h000000EE, 32'h12345000, 32'h12345000, 1'b1, 1'b0, 1'b1);
    drive("sw_auipc",  7'b0010111, 32'h000000EE, 32'h00000099, 32'h00000099, 1'b1, 1'b0, 1'b1);

    // Mid-stream reset pulse between edges while the output holds the immediate.
    drive("pre_rst", 7'b0010011, 32'h0000000A, 32'h00000014, 32'h00000014, 1'b1, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    chk("pre_rst_hold", rs2_out, 32'h00000014);
    rst = 1'b1;
    #1;
    chk("mid_rst_b",   rs2_out, 32'h0);
    chk("mid_rst_sel", {31'd0, sel_imm}, 32'h0);
    chk("mid_rst_ill", {31'd0, op_illegal}, 32'h0);
    rst = 1'b0;
    drive("post_rst", 7'b0110011, 32'h0000000A, 32'h00000014, 32'h0000000A, 1'b0, 1'b0, 1'b0);

    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      @(posedge clk);
      budget++;
    end
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_b_sel
